// File: rtl/updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate limit handling,
// overflow/underflow pulses with sticky copies, and zero/max status.
module updown_counter #(
    parameter int WIDTH       = 32,
    parameter int SATURATE    = 0,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             ovf_sticky,
    output logic             unf_sticky,
    output logic             is_zero,
    output logic             is_max
);

    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VALUE);
    localparam bit               SAT       = (SATURATE != 0);

    // Ripple incrementer: MSB of the result is the carry-out (input was all-ones).
    function automatic logic [WIDTH:0] ripple_inc(input logic [WIDTH-1:0] a);
        logic [WIDTH:0] r;
        logic           c;
        c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = a[i] ^ c;
            c    = c & a[i];
        end
        r[WIDTH] = c;
        return r;
    endfunction

    // Ripple decrementer: MSB of the result is the borrow-out (input was zero).
    function automatic logic [WIDTH:0] ripple_dec(input logic [WIDTH-1:0] a);
        logic [WIDTH:0] r;
        logic           b;
        b = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = a[i] ^ b;
            b    = b & ~a[i];
        end
        r[WIDTH] = b;
        return r;
    endfunction

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             unf_sticky_q, unf_sticky_d;

    logic [WIDTH:0]   inc_w;
    logic [WIDTH:0]   dec_w;
    logic             step;
    logic             ovf_evt;
    logic             unf_evt;

    assign inc_w   = ripple_inc(count_q);
    assign dec_w   = ripple_dec(count_q);
    assign step    = en & ~load;
    assign ovf_evt = step & up & inc_w[WIDTH];
    assign unf_evt = step & ~up & dec_w[WIDTH];

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (step) begin
            if ((ovf_evt || unf_evt) && SAT) begin
                count_d = count_q;
            end else if (up) begin
                count_d = inc_w[WIDTH-1:0];
            end else begin
                count_d = dec_w[WIDTH-1:0];
            end
        end
    end

    // A new event outranks a simultaneous clear.
    always_comb begin
        ovf_d        = ovf_evt;
        unf_d        = unf_evt;
        ovf_sticky_d = (ovf_sticky_q & ~clear_flags) | ovf_evt;
        unf_sticky_d = (unf_sticky_q & ~clear_flags) | unf_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= RST_COUNT;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign count      = count_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;
    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;
    assign is_zero    = (count_q == '0);
    assign is_max     = &count_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: a wrap-mode and a saturate-mode instance
// (WIDTH=4, RESET_VALUE=3) share stimulus and are checked against hand-computed vectors.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load, clear_flags;
    logic [3:0] load_value;

    logic [3:0] count_w, count_s;
    logic       ovf_w, unf_w, os_w, us_w, iz_w, im_w;
    logic       ovf_s, unf_s, os_s, us_s, iz_s, im_s;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4), .SATURATE(0), .RESET_VALUE(3)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_value(load_value), .clear_flags(clear_flags),
        .count(count_w), .ovf(ovf_w), .unf(unf_w),
        .ovf_sticky(os_w), .unf_sticky(us_w), .is_zero(iz_w), .is_max(im_w)
    );

    updown_counter #(.WIDTH(4), .SATURATE(1), .RESET_VALUE(3)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_value(load_value), .clear_flags(clear_flags),
        .count(count_s), .ovf(ovf_s), .unf(unf_s),
        .ovf_sticky(os_s), .unf_sticky(us_s), .is_zero(iz_s), .is_max(im_s)
    );

    // Observed state, packed as {count, ovf, unf, ovf_sticky, unf_sticky, is_zero, is_max}.
    logic [9:0] obs_w, obs_s;
    assign obs_w = {count_w, ovf_w, unf_w, os_w, us_w, iz_w, im_w};
    assign obs_s = {count_s, ovf_s, unf_s, os_s, us_s, iz_s, im_s};

    function automatic logic [9:0] pk(input logic [3:0] c, input logic ov, un, os, us, iz, im);
        return {c, ov, un, os, us, iz, im};
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic r, ld, input logic [3:0] lv, input logic e, u, cf);
        rst = r; load = ld; load_value = lv; en = e; up = u; clear_flags = cf;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            cyc(1, 0, 4'd0, 1, 1, 0);
            n_vec += 2;
            if (obs_w !== pk(4'd3, 0, 0, 0, 0, 0, 0)) begin
                n_miss++;
                $display("FAIL reset_w[%0d]: got %b exp %b", k, obs_w, pk(4'd3, 0, 0, 0, 0, 0, 0));
            end
            if (obs_s !== pk(4'd3, 0, 0, 0, 0, 0, 0)) begin
                n_miss++;
                $display("FAIL reset_s[%0d]: got %b exp %b", k, obs_s, pk(4'd3, 0, 0, 0, 0, 0, 0));
            end
        end
        for (int k = 0; k < 5; k++) begin
            logic [3:0] c;
            c = 4'(4 + k);
            cyc(0, 0, 4'd0, 1, 1, 0);
            n_vec += 2;
            if (obs_w !== pk(c, 0, 0, 0, 0, 0, 0)) begin
                n_miss++;
                $display("FAIL count_up_w[%0d]: got %b exp %b", k, obs_w, pk(c, 0, 0, 0, 0, 0, 0));
            end
            if (obs_s !== pk(c, 0, 0, 0, 0, 0, 0)) begin
                n_miss++;
                $display("FAIL count_up_s[%0d]: got %b exp %b", k, obs_s, pk(c, 0, 0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_wrap_overflow;
        logic [9:0] ew[4];
        logic [9:0] es[4];
        ew[0] = pk(4'd14, 0, 0, 0, 0, 0, 0); es[0] = pk(4'd14, 0, 0, 0, 0, 0, 0);
        ew[1] = pk(4'd15, 0, 0, 0, 0, 0, 1); es[1] = pk(4'd15, 0, 0, 0, 0, 0, 1);
        ew[2] = pk(4'd0,  1, 0, 1, 0, 1, 0); es[2] = pk(4'd15, 1, 0, 1, 0, 0, 1);
        ew[3] = pk(4'd1,  0, 0, 1, 0, 0, 0); es[3] = pk(4'd15, 1, 0, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) cyc(0, 1, 4'd14, 0, 0, 0);
            else        cyc(0, 0, 4'd0, 1, 1, 0);
            n_vec += 2;
            if (obs_w !== ew[k]) begin
                n_miss++;
                $display("FAIL wrap_ovf_w[%0d]: got %b exp %b", k, obs_w, ew[k]);
            end
            if (obs_s !== es[k]) begin
                n_miss++;
                $display("FAIL sat_ovf_s[%0d]: got %b exp %b", k, obs_s, es[k]);
            end
        end
    endtask

    task automatic test_sat_underflow;
        logic [9:0] ew[6];
        logic [9:0] es[6];
        ew[0] = pk(4'd1,  0, 0, 0, 0, 0, 0); es[0] = pk(4'd15, 0, 0, 0, 0, 0, 1);
        ew[1] = pk(4'd1,  0, 0, 0, 0, 0, 0); es[1] = pk(4'd1,  0, 0, 0, 0, 0, 0);
        ew[2] = pk(4'd0,  0, 0, 0, 0, 1, 0); es[2] = pk(4'd0,  0, 0, 0, 0, 1, 0);
        ew[3] = pk(4'd15, 0, 1, 0, 1, 0, 1); es[3] = pk(4'd0,  0, 1, 0, 1, 1, 0);
        ew[4] = pk(4'd14, 0, 0, 0, 1, 0, 0); es[4] = pk(4'd0,  0, 1, 0, 1, 1, 0);
        ew[5] = pk(4'd13, 0, 0, 0, 1, 0, 0); es[5] = pk(4'd0,  0, 1, 0, 1, 1, 0);
        for (int k = 0; k < 6; k++) begin
            if (k == 0)      cyc(0, 0, 4'd0, 0, 0, 1);
            else if (k == 1) cyc(0, 1, 4'd1, 0, 0, 0);
            else             cyc(0, 0, 4'd0, 1, 0, 0);
            n_vec += 2;
            if (obs_w !== ew[k]) begin
                n_miss++;
                $display("FAIL wrap_unf_w[%0d]: got %b exp %b", k, obs_w, ew[k]);
            end
            if (obs_s !== es[k]) begin
                n_miss++;
                $display("FAIL sat_unf_s[%0d]: got %b exp %b", k, obs_s, es[k]);
            end
        end
    endtask

    task automatic test_priority;
        cyc(0, 1, 4'd9, 1, 1, 0);
        n_vec += 2;
        if (obs_w !== pk(4'd9, 0, 0, 0, 1, 0, 0)) begin
            n_miss++;
            $display("FAIL load_over_en_w: got %b exp %b", obs_w, pk(4'd9, 0, 0, 0, 1, 0, 0));
        end
        if (obs_s !== pk(4'd9, 0, 0, 0, 1, 0, 0)) begin
            n_miss++;
            $display("FAIL load_over_en_s: got %b exp %b", obs_s, pk(4'd9, 0, 0, 0, 1, 0, 0));
        end
        cyc(1, 1, 4'd12, 1, 1, 0);
        n_vec += 2;
        if (obs_w !== pk(4'd3, 0, 0, 0, 0, 0, 0)) begin
            n_miss++;
            $display("FAIL rst_over_load_w: got %b exp %b", obs_w, pk(4'd3, 0, 0, 0, 0, 0, 0));
        end
        if (obs_s !== pk(4'd3, 0, 0, 0, 0, 0, 0)) begin
            n_miss++;
            $display("FAIL rst_over_load_s: got %b exp %b", obs_s, pk(4'd3, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_sticky_race;
        logic [9:0] ew[3];
        logic [9:0] es[3];
        ew[0] = pk(4'd15, 0, 0, 0, 0, 0, 1); es[0] = pk(4'd15, 0, 0, 0, 0, 0, 1);
        ew[1] = pk(4'd0,  1, 0, 1, 0, 1, 0); es[1] = pk(4'd15, 1, 0, 1, 0, 0, 1);
        ew[2] = pk(4'd0,  0, 0, 0, 0, 1, 0); es[2] = pk(4'd15, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      cyc(0, 1, 4'd15, 0, 0, 0);
            else if (k == 1) cyc(0, 0, 4'd0, 1, 1, 1);
            else             cyc(0, 0, 4'd0, 0, 0, 1);
            n_vec += 2;
            if (obs_w !== ew[k]) begin
                n_miss++;
                $display("FAIL sticky_race_w[%0d]: got %b exp %b", k, obs_w, ew[k]);
            end
            if (obs_s !== es[k]) begin
                n_miss++;
                $display("FAIL sticky_race_s[%0d]: got %b exp %b", k, obs_s, es[k]);
            end
        end
    endtask

    task automatic test_direction;
        logic [3:0] ec[6];
        logic       de[6];
        logic       du[6];
        ec[0] = 4'd5; de[0] = 0; du[0] = 0;
        ec[1] = 4'd6; de[1] = 1; du[1] = 1;
        ec[2] = 4'd5; de[2] = 1; du[2] = 0;
        ec[3] = 4'd4; de[3] = 1; du[3] = 0;
        ec[4] = 4'd4; de[4] = 0; du[4] = 1;
        ec[5] = 4'd4; de[5] = 0; du[5] = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(0, (k == 0), 4'd5, de[k], du[k], 0);
            n_vec += 2;
            if (obs_w !== pk(ec[k], 0, 0, 0, 0, 0, 0)) begin
                n_miss++;
                $display("FAIL direction_w[%0d]: got %b exp %b", k, obs_w, pk(ec[k], 0, 0, 0, 0, 0, 0));
            end
            if (obs_s !== pk(ec[k], 0, 0, 0, 0, 0, 0)) begin
                n_miss++;
                $display("FAIL direction_s[%0d]: got %b exp %b", k, obs_s, pk(ec[k], 0, 0, 0, 0, 0, 0));
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0;
        load_value = 4'd0; clear_flags = 1'b0;
        test_reset();
        test_wrap_overflow();
        test_sat_underflow();
        test_priority();
        test_sticky_race();
        test_direction();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
